fp_divider: RTL and testbench

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_classify.sv | 35 +++
 rtl/fp_divider.sv | 197 +++++++++++++++++++
 tb/tb_fp_divider.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision constants, flag positions and the divider FSM state type.
package fp_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXPI_W   = 10;
  localparam int unsigned QUO_BITS = 25;
  localparam int unsigned REM_W    = 25;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  localparam logic [2:0]  FLAG_INVALID  = 3'b100;
  localparam logic [2:0]  FLAG_DIV_ZERO = 3'b010;
  localparam logic [2:0]  FLAG_OVERFLOW = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/fp_classify.sv
// Decodes an IEEE-754 single word into class bits, sign, biased exponent and
// 24-bit mantissa with the hidden bit made explicit.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0]       word,
  output logic              is_zero,
  output logic              is_sub,
  output logic              is_inf,
  output logic              is_nan,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant24
);

  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_ones;
  logic              frac_zero;

  always_comb begin
    sign      = word[31];
    exp       = word[30:23];
    frac      = word[22:0];
    exp_zero  = (exp == '0);
    exp_ones  = (exp == '1);
    frac_zero = (frac == '0);
    is_zero   = exp_zero & frac_zero;
    is_sub    = exp_zero & ~frac_zero;
    is_inf    = exp_ones & frac_zero;
    is_nan    = exp_ones & ~frac_zero;
    mant24    = {~exp_zero, frac};
  end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single-precision divider: restoring division one bit per
// cycle, round-to-nearest-even, subnormals flushed to zero on input and output.
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [2:0]  flags
);

  logic              a_zero_raw, a_sub, a_inf, a_nan, a_sign;
  logic              b_zero_raw, b_sub, b_inf, b_nan, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;

  fp_classify u_cls_a (
    .word(a), .is_zero(a_zero_raw), .is_sub(a_sub), .is_inf(a_inf),
    .is_nan(a_nan), .sign(a_sign), .exp(a_exp), .mant24(a_mant)
  );

  fp_classify u_cls_b (
    .word(b), .is_zero(b_zero_raw), .is_sub(b_sub), .is_inf(b_inf),
    .is_nan(b_nan), .sign(b_sign), .exp(b_exp), .mant24(b_mant)
  );

  state_e                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic signed [EXPI_W-1:0]  exp_q, exp_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [MANT_W-1:0]         dvs_q, dvs_d;
  logic [QUO_BITS-1:0]       quo_q, quo_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [31:0]               quotient_q, quotient_d;
  logic [2:0]                flags_q, flags_d;
  logic                      out_valid_q, out_valid_d;

  logic        a_zero, b_zero, sign_in, special;
  logic [31:0] spec_word;
  logic [2:0]  spec_flags;

  // Subnormal operands are treated as signed zero.
  always_comb begin
    a_zero     = a_zero_raw | a_sub;
    b_zero     = b_zero_raw | b_sub;
    sign_in    = a_sign ^ b_sign;
    special    = 1'b1;
    spec_word  = '0;
    spec_flags = '0;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_word  = QNAN;
      spec_flags = FLAG_INVALID;
    end else if (a_inf) begin
      spec_word  = {sign_in, POS_INF[30:0]};
    end else if (b_zero) begin
      spec_word  = {sign_in, POS_INF[30:0]};
      spec_flags = FLAG_DIV_ZERO;
    end else if (a_zero | b_inf) begin
      spec_word  = {sign_in, 31'b0};
    end else begin
      special    = 1'b0;
    end
  end

  logic signed [EXPI_W-1:0] exp_diff;
  logic                     mant_lt;
  logic                     rem_ge;
  logic [REM_W-1:0]         rem_diff;
  logic                     guard, sticky, round_up;
  logic [MANT_W:0]          mant_rnd;
  logic signed [EXPI_W-1:0] exp_rnd;
  logic [FRAC_W-1:0]        frac_rnd;

  always_comb begin
    exp_diff = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp});
    mant_lt  = (a_mant < b_mant);
    rem_ge   = (rem_q >= {1'b0, dvs_q});
    rem_diff = rem_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    guard    = quo_q[0];
    sticky   = |rem_q;
    round_up = guard & (sticky | quo_q[1]);
    mant_rnd = {1'b0, quo_q[QUO_BITS-1:1]} + {{MANT_W{1'b0}}, round_up};
    // A carry out of the 24-bit mantissa can only leave 1.0 behind.
    if (mant_rnd[MANT_W]) begin
      frac_rnd = '0;
      exp_rnd  = exp_q + 10'sd1;
    end else begin
      frac_rnd = mant_rnd[FRAC_W-1:0];
      exp_rnd  = exp_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          flags_d = '0;
          sign_d  = sign_in;
          if (special) begin
            quotient_d = spec_word;
            flags_d    = spec_flags;
            state_d    = DONE;
          end else begin
            dvs_d = b_mant;
            quo_d = '0;
            cnt_d = '0;
            if (mant_lt) begin
              rem_d = {a_mant, 1'b0};
              exp_d = exp_diff + 10'(EXP_BIAS - 1);
            end else begin
              rem_d = {1'b0, a_mant};
              exp_d = exp_diff + 10'(EXP_BIAS);
            end
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_diff << 1;
        quo_d = {quo_q[QUO_BITS-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QUO_BITS - 1)) state_d = ROUND;
      end
      ROUND: begin
        if (exp_rnd >= 10'sd255) begin
          quotient_d = {sign_q, POS_INF[30:0]};
          flags_d    = FLAG_OVERFLOW;
        end else if (exp_rnd <= 10'sd0) begin
          quotient_d = {sign_q, 31'b0};
        end else begin
          quotient_d = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Special results enter DONE with out_valid low; it rises one cycle later.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed corner cases plus random operands
// against an exact-remainder reference model.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  fp_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact quotient significand and remainder, then RNE from the remainder.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [2:0] f,
                                  output int lat);
    int     ex, ey, e;
    logic   s;
    bit     zx, zy, ix, iy, nx, ny;
    longint mx, my, num, sig, rem;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    s   = x[31] ^ y[31];
    f   = 3'b000;
    lat = 1;
    if (nx || ny || (zx && zy) || (ix && iy)) begin
      q = 32'h7FC00000;
      f = 3'b100;
    end else if (ix) begin
      q = {s, 8'hFF, 23'h0};
    end else if (zy) begin
      q = {s, 8'hFF, 23'h0};
      f = 3'b010;
    end else if (zx || iy) begin
      q = {s, 31'h0};
    end else begin
      lat = 26;
      mx  = longint'(x[22:0]) + 64'd8388608;
      my  = longint'(y[22:0]) + 64'd8388608;
      e   = ex - ey + 127;
      num = mx;
      if (mx < my) begin
        num = mx * 2;
        e   = e - 1;
      end
      sig = (num * 8388608) / my;
      rem = (num * 8388608) % my;
      if ((2 * rem > my) || ((2 * rem == my) && (sig % 2 == 1))) sig = sig + 1;
      if (sig == 64'd16777216) begin
        sig = sig / 2;
        e   = e + 1;
      end
      if (e >= 255) begin
        q = {s, 8'hFF, 23'h0};
        f = 3'b001;
      end else if (e <= 0) begin
        q = {s, 31'h0};
      end else begin
        q = {s, 8'(e), 23'(sig)};
      end
    end
  endfunction

  task automatic start_op(input logic [31:0] ai, input logic [31:0] bi);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    a        = ai;
    b        = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid after handshake", 32'(out_valid), 32'd0);
    check("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi);
    logic [31:0] eq;
    logic [2:0]  ef;
    int          elat, lat;
    ref_div(ai, bi, eq, ef, elat);
    start_op(ai, bi);
    wait_result(lat);
    check($sformatf("latency %h/%h", ai, bi), 32'(lat), 32'(elat));
    check($sformatf("quotient %h/%h", ai, bi), quotient, eq);
    check($sformatf("flags %h/%h", ai, bi), 32'(flags), 32'(ef));
    handshake();
  endtask

  initial begin
    logic [31:0] held_q;
    logic [2:0]  held_f;
    logic [31:0] ra, rb;
    int          lat;
    bit          seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset quotient", quotient, 32'h0);
    check("reset flags", 32'(flags), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'h40C00000, 32'h40000000);
    run_op(32'h3F800000, 32'h40400000);
    run_op(32'h3F800000, 32'h00000000);
    run_op(32'h00000000, 32'h00000000);
    run_op(32'h7F000000, 32'h3E800000);
    run_op(32'h00800000, 32'h4B000000);
    run_op(32'hFF800000, 32'h40000000);
    run_op(32'h7F800000, 32'hFF800000);
    run_op(32'h40000000, 32'hFF800000);
    run_op(32'h7FC12345, 32'h3F800000);
    run_op(32'h00400000, 32'hC0000000);
    run_op(32'hC0A00000, 32'h00001000);
    run_op(32'h3F800000, 32'h3F800001);
    run_op(32'h00000000, 32'hC2000000);

    for (int i = 0; i < 40; i++) begin
      ra = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
      run_op(ra, rb);
    end
    for (int i = 0; i < 10; i++) begin
      run_op($urandom, $urandom);
    end

    // Busy-time in_valid pulses and output hold under back-pressure.
    start_op(32'h40C00000, 32'h40000000);
    repeat (3) @(posedge clk);
    #1;
    a        = 32'h3F800000;
    b        = 32'h00000000;
    in_valid = 1'b1;
    check("in_ready during DIV", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat);
    check("stall latency", 32'(lat + 6), 32'd26);
    check("stall quotient", quotient, 32'h40400000);
    held_q = quotient;
    held_f = flags;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      #1;
      check($sformatf("hold quotient c%0d", k), quotient, held_q);
      check($sformatf("hold flags c%0d", k), 32'(flags), 32'(held_f));
      check($sformatf("hold out_valid c%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("hold in_ready c%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no stray result after stall", 32'(seen), 32'd0);

    // Reset in the middle of DIV discards the operation.
    run_op(32'hC0400000, 32'h3F000000);
    start_op(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst quotient", quotient, 32'h0);
    check("midrst flags", 32'(flags), 32'h0);
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no output after midrst", 32'(seen), 32'd0);
    run_op(32'h3F800000, 32'h40400000);
    run_op(32'h40C00000, 32'h40000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
